reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of rename.
- Each cycle it accepts up to 2 renamed µops into a circular queue and tags each with a ROB index.
- It marks entries done on writeback from up to 3 functional units.
- It retires up to 3 consecutive done entries from the head. Each retirement is emitted as a rob_row_struct so rename can return OldPRegAddrDst to the free pool.

Parameters:
- ROB_DEPTH, 16, number of entries; power of 2, at least 4.
- TAG_W, $clog2(ROB_DEPTH), ROB index width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rename_data  in  rename_struct [0:1]  µops from rename
- i_rename_valid  in  2  per-slot valid
- o_alloc_ready  out  1  ROB can take 2 entries this cycle
- o_rob_tag  out  TAG_W [0:1]  index assigned to each slot (combinational)
- i_wb_valid  in  3  writeback valid per FU
- i_wb_tag  in  TAG_W [0:2]  ROB index completing
- o_retire_rows  out  rob_row_struct [0:2]  retired rows (valid, PRegAddrDst, OldPRegAddrDst, ARegAddrDst)
- o_count  out  TAG_W+1  occupied entries

Behaviour:
- Storage:
  - Entry array holds valid, done, ARegAddrDst, PRegAddrDst and OldPRegAddrDst.
  - head and tail pointers are TAG_W+1 bits; the MSB is a wrap bit.
  - count = tail - head.
- Reset (async, i_rst_n=0):
  - All entry valid/done bits = 0; head = tail = 0.
  - o_retire_rows[*].valid = 0, other fields 0.
  - o_count = 0; o_alloc_ready = 1.
- o_alloc_ready:
  - Equals (ROB_DEPTH - count >= 2), computed from the registered count only.
  - Space freed by same-cycle retirement is not counted.
- Allocation:
  - Slots are accepted only when o_alloc_ready=1. Allocation is all-or-nothing: valid slots are never partially accepted.
  - Valid slots are compacted in order. Slot 0 gets tail; slot 1 gets tail+1 if slot 0 is valid, else tail.
  - o_rob_tag reflects this combinationally.
  - A new entry is written with valid=1, done=0; tail advances by popcount(i_rename_valid).
  - If i_rename_valid≠0 while o_alloc_ready=0, the input is ignored. Upstream must hold it.
- Completion:
  - For each i_wb_valid[k], set done on entry i_wb_tag[k].
  - Duplicate tags in one cycle are legal and idempotent.
  - A tag pointing at an invalid entry is ignored; simulation issues $error.
- Retire:
  - Scan head, head+1 and head+2 using the state at the clock edge. Retire the longest done-prefix of length r (0..3), stopping at the first invalid or not-done entry.
  - Retired rows are registered onto o_retire_rows[0..r-1] with valid=1 in the next cycle (1-cycle latency). Remaining slots get valid=0.
  - Retired entries are cleared; head += r.
  - Writebacks in cycle N are not visible to retire until N+1 (done is registered).
- Simultaneous events:
  - Same-cycle alloc, writeback and retire all act on disjoint entries.
  - count_next = count + alloc - r.
- Boundaries:
  - Full: count = ROB_DEPTH, o_alloc_ready=0. Count = ROB_DEPTH-1 also gives ready=0.
  - Empty: retire outputs all invalid.
  - Index wraps modulo ROB_DEPTH; the wrap bit distinguishes full from empty.
  - ARegAddrDst = 0 entries retire normally with OldPRegAddrDst = 0, which rename ignores.
- Reset mid-operation discards all in-flight entries immediately.

Optional Feature:
- Macro ROB_FLUSH_EN.
- With it defined:
  - Adds input i_flush (1 bit).
  - When i_flush=1 at a clock edge, all valid/done bits clear, tail = head, and o_retire_rows valid bits go 0 next cycle.
  - Flush has priority over alloc, writeback and retire in that cycle; o_alloc_ready=1 the following cycle.
- Without it: no i_flush port and no flush logic.

Decomposition:
- Types package:
  - rob_row_struct gains ARegAddrDst and PRegAddrDst.
  - Add a rob_entry_struct (valid, done, ARegAddrDst, PRegAddrDst, OldPRegAddrDst).
  - ROB_DEPTH and the retire width (3) become package constants.
- One sub-module: rob_retire_select, a combinational done-prefix finder returning r and the per-slot retire enables.

Test Plan:
- Reset then idle: o_count=0, o_alloc_ready=1, all o_retire_rows valid=0.
- Allocate 2 µops (Dst P33, P34; Old P5, P6); no writeback: tags 0,1; o_count=2; nothing retires.
- Writeback tag 1 then tag 0 in later cycles: no retire after tag 1. The cycle after tag 0's done, rows[0]={P33,Old P5} and rows[1]={P34,Old P6} both valid; o_count=0.
- Fill 16 entries, then hold i_rename_valid=2'b11: o_alloc_ready=0 at count 15 and 16; tail unchanged.
- Wrap: head=14, 4 entries done; retire 3 then 1. Rows show entries 14, 15, 0, then 1; o_count reaches 0.
- ROB_FLUSH_EN: allocate 6, assert i_flush with a same-cycle writeback: count=0 next cycle, no retire output, o_alloc_ready=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing constants for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);
  localparam int unsigned ALLOC_W   = 2;
  localparam int unsigned WB_W      = 3;
  localparam int unsigned RETIRE_W  = 3;
  localparam int unsigned RET_CNT_W = $clog2(RETIRE_W + 1);
  localparam int unsigned AREG_W    = 5;
  localparam int unsigned PREG_W    = 6;

  typedef struct packed {
    logic [AREG_W-1:0] ARegAddrDst;
    logic [PREG_W-1:0] PRegAddrDst;
    logic [PREG_W-1:0] OldPRegAddrDst;
  } rename_struct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] PRegAddrDst;
    logic [PREG_W-1:0] OldPRegAddrDst;
    logic [AREG_W-1:0] ARegAddrDst;
  } rob_row_struct;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] ARegAddrDst;
    logic [PREG_W-1:0] PRegAddrDst;
    logic [PREG_W-1:0] OldPRegAddrDst;
  } rob_entry_struct;

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Combinational done-prefix finder over the oldest RETIRE_W entries.
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  logic [RETIRE_W-1:0]  slot_valid,
  input  logic [RETIRE_W-1:0]  slot_done,
  output logic [RETIRE_W-1:0]  retire_en,
  output logic [RET_CNT_W-1:0] retire_cnt
);

  always_comb begin
    logic run;
    run        = 1'b1;
    retire_en  = '0;
    retire_cnt = '0;
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      run          = run & slot_valid[i] & slot_done[i];
      retire_en[i] = run;
      if (run) begin
        retire_cnt = retire_cnt + RET_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: 2-wide allocate, 3-port writeback, 3-wide retire.
// Define ROB_FLUSH_EN to add the i_flush port and whole-buffer flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef ROB_FLUSH_EN
  input  logic             i_flush,
`endif
  input  rename_struct     i_rename_data [0:1],
  input  logic [1:0]       i_rename_valid,
  output logic             o_alloc_ready,
  output logic [TAG_W-1:0] o_rob_tag [0:1],
  input  logic [2:0]       i_wb_valid,
  input  logic [TAG_W-1:0] i_wb_tag [0:2],
  output rob_row_struct    o_retire_rows [0:2],
  output logic [TAG_W:0]   o_count
);

  rob_entry_struct      rob_q [ROB_DEPTH];
  rob_entry_struct      rob_d [ROB_DEPTH];
  rob_row_struct        rows_d [RETIRE_W];
  logic [TAG_W:0]       head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0]     head_idx, tail_idx;
  logic [RETIRE_W-1:0]  slot_valid, slot_done, retire_en;
  logic [RET_CNT_W-1:0] retire_cnt;
  logic [1:0]           alloc_cnt;
  logic                 alloc_fire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Wrap bit makes the difference correct for both full and empty.
  assign o_count       = tail_q - head_q;
  assign o_alloc_ready = (o_count <= (TAG_W+1)'(ROB_DEPTH - 2));

  assign o_rob_tag[0] = tail_idx;
  assign o_rob_tag[1] = tail_idx + TAG_W'(i_rename_valid[0]);

  assign alloc_cnt  = {1'b0, i_rename_valid[0]} + {1'b0, i_rename_valid[1]};
  assign alloc_fire = o_alloc_ready && (i_rename_valid != '0);

  always_comb begin
    slot_valid = '0;
    slot_done  = '0;
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      slot_valid[i] = rob_q[head_idx + TAG_W'(i)].valid;
      slot_done[i]  = rob_q[head_idx + TAG_W'(i)].done;
    end
  end

  rob_retire_select u_retire_select (
    .slot_valid (slot_valid),
    .slot_done  (slot_done),
    .retire_en  (retire_en),
    .retire_cnt (retire_cnt)
  );

  always_comb begin
    logic [TAG_W-1:0] idx;
    idx    = '0;
    rob_d  = rob_q;
    head_d = head_q + (TAG_W+1)'(retire_cnt);
    tail_d = tail_q;

    for (int unsigned k = 0; k < WB_W; k++) begin
      if (i_wb_valid[k] && rob_q[i_wb_tag[k]].valid) begin
        rob_d[i_wb_tag[k]].done = 1'b1;
      end
    end

    // Retire clear follows writeback so a redundant writeback cannot revive a retiring slot.
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      idx       = head_idx + TAG_W'(i);
      rows_d[i] = '0;
      if (retire_en[i]) begin
        rows_d[i].valid          = 1'b1;
        rows_d[i].PRegAddrDst    = rob_q[idx].PRegAddrDst;
        rows_d[i].OldPRegAddrDst = rob_q[idx].OldPRegAddrDst;
        rows_d[i].ARegAddrDst    = rob_q[idx].ARegAddrDst;
        rob_d[idx]               = '0;
      end
    end

    if (alloc_fire) begin
      tail_d = tail_q + (TAG_W+1)'(alloc_cnt);
      for (int unsigned s = 0; s < ALLOC_W; s++) begin
        if (i_rename_valid[s]) begin
          rob_d[o_rob_tag[s]].valid          = 1'b1;
          rob_d[o_rob_tag[s]].done           = 1'b0;
          rob_d[o_rob_tag[s]].ARegAddrDst    = i_rename_data[s].ARegAddrDst;
          rob_d[o_rob_tag[s]].PRegAddrDst    = i_rename_data[s].PRegAddrDst;
          rob_d[o_rob_tag[s]].OldPRegAddrDst = i_rename_data[s].OldPRegAddrDst;
        end
      end
    end

`ifdef ROB_FLUSH_EN
    if (i_flush) begin
      rob_d  = '{default: '0};
      rows_d = '{default: '0};
      head_d = head_q;
      tail_d = head_q;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rob_q         <= '{default: '0};
      o_retire_rows <= '{default: '0};
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      rob_q         <= rob_d;
      o_retire_rows <= rows_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      for (int unsigned k = 0; k < WB_W; k++) begin
        if (i_wb_valid[k] && !rob_q[i_wb_tag[k]].valid) begin
          $error("reorder_buffer: writeback to invalid entry %0d", i_wb_tag[k]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
// Define ROB_FLUSH_EN to also exercise the flush path.
`timescale 1ns/1ps
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  rename_struct     rn_data [0:1];
  logic [1:0]       rn_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] rob_tag [0:1];
  logic [2:0]       wb_valid;
  logic [TAG_W-1:0] wb_tag [0:2];
  rob_row_struct    rows [0:2];
  logic [TAG_W:0]   count;
`ifdef ROB_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
`ifdef ROB_FLUSH_EN
    .i_flush        (flush),
`endif
    .i_rename_data  (rn_data),
    .i_rename_valid (rn_valid),
    .o_alloc_ready  (alloc_ready),
    .o_rob_tag      (rob_tag),
    .i_wb_valid     (wb_valid),
    .i_wb_tag       (wb_tag),
    .o_retire_rows  (rows),
    .o_count        (count)
  );

  always #5 i_clk = ~i_clk;

  // Program-order list of in-flight uops; entry i lives at ROB index (head_seq + i) mod depth.
  typedef struct {
    logic [AREG_W-1:0] a;
    logic [PREG_W-1:0] p;
    logic [PREG_W-1:0] o;
    bit                done;
  } uop_t;

  uop_t          mq[$];
  int unsigned   head_seq = 0;
  rob_row_struct exp_rows [0:2];

  function automatic bit m_ready();
    return (int'(ROB_DEPTH) - mq.size()) >= 2;
  endfunction

  function automatic int unsigned m_tag(int slot);
    int unsigned base = (head_seq + mq.size()) % ROB_DEPTH;
    return (slot == 0) ? base : (base + rn_valid[0]) % ROB_DEPTH;
  endfunction

  task automatic idle();
    rn_valid = '0;
    wb_valid = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic rand_data();
    for (int s = 0; s < 2; s++) begin
      rn_data[s].ARegAddrDst    = AREG_W'($urandom);
      rn_data[s].PRegAddrDst    = PREG_W'($urandom);
      rn_data[s].OldPRegAddrDst = PREG_W'($urandom);
    end
  endtask

  task automatic rand_wb(int pct);
    wb_valid = '0;
    for (int k = 0; k < 3; k++) begin
      wb_tag[k] = '0;
      if (mq.size() != 0 && $urandom_range(0, 99) < pct) begin
        wb_valid[k] = 1'b1;
        wb_tag[k]   = TAG_W'((head_seq + $urandom_range(0, mq.size() - 1)) % ROB_DEPTH);
      end
    end
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    int r = 0;
    bit ready = m_ready();
    while (r < 3 && r < mq.size() && mq[r].done) r++;
    for (int i = 0; i < 3; i++) begin
      exp_rows[i] = '0;
      if (i < r) begin
        exp_rows[i].valid          = 1'b1;
        exp_rows[i].PRegAddrDst    = mq[i].p;
        exp_rows[i].OldPRegAddrDst = mq[i].o;
        exp_rows[i].ARegAddrDst    = mq[i].a;
      end
    end
`ifdef ROB_FLUSH_EN
    if (flush) begin
      mq.delete();
      for (int i = 0; i < 3; i++) exp_rows[i] = '0;
    end else begin
`else
    begin
`endif
      for (int k = 0; k < 3; k++) begin
        if (wb_valid[k]) begin
          int unsigned off = (int'(wb_tag[k]) + ROB_DEPTH - head_seq) % ROB_DEPTH;
          if (off < mq.size()) mq[off].done = 1'b1;
        end
      end
      repeat (r) void'(mq.pop_front());
      head_seq = (head_seq + r) % ROB_DEPTH;
      if (ready) begin
        for (int s = 0; s < 2; s++) begin
          if (rn_valid[s]) begin
            uop_t u;
            u.a = rn_data[s].ARegAddrDst;
            u.p = rn_data[s].PRegAddrDst;
            u.o = rn_data[s].OldPRegAddrDst;
            u.done = 1'b0;
            mq.push_back(u);
          end
        end
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    mq.delete();
    head_seq = 0;
    for (int i = 0; i < 3; i++) exp_rows[i] = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && mq.size() != 0; c++) begin
      rn_valid = '0;
      rand_wb(60);
      #1;
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", alloc_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rows[i] !== '0) begin errors++; $display("FAIL reset_row%0d: got %h expected 0", i, rows[i]); end
    end
  endtask

  task automatic test_alloc_basic();
    rn_data[0].ARegAddrDst = 5'd3; rn_data[0].PRegAddrDst = 6'd33; rn_data[0].OldPRegAddrDst = 6'd5;
    rn_data[1].ARegAddrDst = 5'd4; rn_data[1].PRegAddrDst = 6'd34; rn_data[1].OldPRegAddrDst = 6'd6;
    rn_valid = 2'b11;
    #1;
    checks++; if (rob_tag[0] !== 4'd0) begin errors++; $display("FAIL alloc_tag0: got %0d expected 0", rob_tag[0]); end
    checks++; if (rob_tag[1] !== 4'd1) begin errors++; $display("FAIL alloc_tag1: got %0d expected 1", rob_tag[1]); end
    tick();
    idle();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL alloc_count: got %0d expected 2", count); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rows[i].valid !== 1'b0) begin errors++; $display("FAIL alloc_no_retire%0d: got %b expected 0", i, rows[i].valid); end
    end
  endtask

  task automatic test_writeback_order();
    rob_row_struct e0, e1;
    e0 = '0; e0.valid = 1'b1; e0.PRegAddrDst = 6'd33; e0.OldPRegAddrDst = 6'd5; e0.ARegAddrDst = 5'd3;
    e1 = '0; e1.valid = 1'b1; e1.PRegAddrDst = 6'd34; e1.OldPRegAddrDst = 6'd6; e1.ARegAddrDst = 5'd4;
    wb_valid = 3'b001; wb_tag[0] = 4'd1;
    #1; tick(); idle();
    #1; tick();
    checks++; if (rows[0].valid !== 1'b0) begin errors++; $display("FAIL wb1_no_retire: got %b expected 0", rows[0].valid); end
    wb_valid = 3'b010; wb_tag[1] = 4'd0;
    #1; tick(); idle();
    checks++; if (rows[0].valid !== 1'b0) begin errors++; $display("FAIL wb0_same_cycle: got %b expected 0", rows[0].valid); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL wb0_count: got %0d expected 2", count); end
    #1; tick();
    checks++; if (rows[0] !== e0) begin errors++; $display("FAIL wb_row0: got %h expected %h", rows[0], e0); end
    checks++; if (rows[1] !== e1) begin errors++; $display("FAIL wb_row1: got %h expected %h", rows[1], e1); end
    checks++; if (rows[2].valid !== 1'b0) begin errors++; $display("FAIL wb_row2: got %b expected 0", rows[2].valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wb_count: got %0d expected 0", count); end
  endtask

  task automatic test_full();
    logic [TAG_W-1:0] held_tag;
    for (int c = 0; c < 7; c++) begin
      rand_data(); rn_valid = 2'b11;
      #1;
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b expected 1", c, alloc_ready); end
      tick();
    end
    rand_data(); rn_valid = 2'b01;
    #1; tick();
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL full15_count: got %0d expected 15", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full15_ready: got %b expected 0", alloc_ready); end
    rand_data(); rn_valid = 2'b11;
    #1;
    held_tag = TAG_W'(m_tag(0));
    tick(); tick();
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL full15_hold: got %0d expected 15", count); end
    checks++; if (rob_tag[0] !== held_tag) begin errors++; $display("FAIL full15_tail: got %0d expected %0d", rob_tag[0], held_tag); end
    idle(); wb_valid = 3'b001; wb_tag[0] = TAG_W'(head_seq);
    #1; tick(); idle();
    #1; tick();
    checks++; if (count !== 5'd14) begin errors++; $display("FAIL full_retire1: got %0d expected 14", count); end
    rand_data(); rn_valid = 2'b11;
    #1; tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full16_count: got %0d expected 16", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full16_ready: got %b expected 0", alloc_ready); end
    #1; tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full16_hold: got %0d expected 16", count); end
    idle();
    drain();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      rand_data(); rn_valid = 2'b11;
      #1; tick();
    end
    idle();
    drain();
    rand_data(); rn_valid = 2'b11;
    #1;
    checks++; if (rob_tag[0] !== 4'd14) begin errors++; $display("FAIL wrap_tag14: got %0d expected 14", rob_tag[0]); end
    checks++; if (rob_tag[1] !== 4'd15) begin errors++; $display("FAIL wrap_tag15: got %0d expected 15", rob_tag[1]); end
    tick();
    rand_data();
    #1;
    checks++; if (rob_tag[0] !== 4'd0) begin errors++; $display("FAIL wrap_tag0: got %0d expected 0", rob_tag[0]); end
    checks++; if (rob_tag[1] !== 4'd1) begin errors++; $display("FAIL wrap_tag1: got %0d expected 1", rob_tag[1]); end
    tick();
    idle();
    wb_valid = 3'b111; wb_tag[0] = 4'd14; wb_tag[1] = 4'd15; wb_tag[2] = 4'd0;
    #1; tick();
    wb_valid = 3'b001; wb_tag[0] = 4'd1;
    #1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rows[i] !== exp_rows[i] || rows[i].valid !== 1'b1) begin errors++; $display("FAIL wrap_ret3_row%0d: got %h expected %h", i, rows[i], exp_rows[i]); end
    end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL wrap_ret3_count: got %0d expected 1", count); end
    #1; tick();
    checks++; if (rows[0] !== exp_rows[0] || rows[0].valid !== 1'b1) begin errors++; $display("FAIL wrap_ret1_row0: got %h expected %h", rows[0], exp_rows[0]); end
    checks++; if (rows[1].valid !== 1'b0) begin errors++; $display("FAIL wrap_ret1_row1: got %b expected 0", rows[1].valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_ret1_count: got %0d expected 0", count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      rn_valid = 2'($urandom_range(0, 3));
      rand_wb((c % 100 < 50) ? 15 : 55);
      #1;
      checks++; if (alloc_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, alloc_ready, m_ready()); end
      checks++; if (rob_tag[0] !== TAG_W'(m_tag(0))) begin errors++; $display("FAIL rnd_tag0 c%0d: got %0d expected %0d", c, rob_tag[0], m_tag(0)); end
      checks++; if (rob_tag[1] !== TAG_W'(m_tag(1))) begin errors++; $display("FAIL rnd_tag1 c%0d: got %0d expected %0d", c, rob_tag[1], m_tag(1)); end
      checks++; if (count !== (TAG_W+1)'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, mq.size()); end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++; if (rows[i] !== exp_rows[i]) begin errors++; $display("FAIL rnd_row%0d c%0d: got %h expected %h", i, c, rows[i], exp_rows[i]); end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rand_data(); rn_valid = 2'b11;
    #1; tick(); idle();
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", alloc_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rows[i] !== '0) begin errors++; $display("FAIL rstmid_row%0d: got %h expected 0", i, rows[i]); end
    end
    do_reset();
    rand_data(); rn_valid = 2'b10;
    #1;
    checks++; if (rob_tag[1] !== 4'd0) begin errors++; $display("FAIL rstmid_tag: got %0d expected 0", rob_tag[1]); end
    tick(); idle();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL rstmid_alloc: got %0d expected 1", count); end
    drain();
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rand_data(); rn_valid = 2'b11;
      if (c == 2) begin wb_valid = 3'b001; wb_tag[0] = 4'd0; end
      #1; tick();
    end
    idle();
    flush = 1'b1; wb_valid = 3'b010; wb_tag[1] = 4'd1;
    #1; tick(); idle();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", alloc_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rows[i].valid !== 1'b0) begin errors++; $display("FAIL flush_row%0d: got %b expected 0", i, rows[i].valid); end
    end
    #1; tick();
    checks++; if (rows[0].valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b expected 0", rows[0].valid); end
    rand_data(); rn_valid = 2'b01;
    #1;
    checks++; if (rob_tag[0] !== 4'd0) begin errors++; $display("FAIL flush_tag: got %0d expected 0", rob_tag[0]); end
    tick(); idle();
    drain();
  endtask
`endif

  initial begin
    idle();
    rand_data();
    for (int k = 0; k < 3; k++) wb_tag[k] = '0;
    test_reset();
    test_alloc_basic();
    test_writeback_order();
    test_full();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
